rv_mem_arb: RTL and testbench
=============================

# rv_mem_arb

Two-port arbiter that shares the single-port synchronous main memory of the multicycle RISC-V core between the core (instruction fetch and load/store) and a DMA/program-loader requester. Each requester issues one transaction at a time with a level request and receives a one-cycle acknowledge. Requests are latched, issued to memory, waited out for the fixed read latency, and answered with registered read data. Ties are resolved round-robin so neither side starves.

## Interface
- RD_LAT, 1, memory read latency in cycles from the issue cycle to valid `mem_rdata`; legal range 1..4.
- AW, 32, address width.
- DW, 32, data width.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- core_req  in  1  core request; level, held until `core_ack`.
- core_we  in  1  1 = write, 0 = read; sampled with the grant.
- core_addr  in  AW  core address; sampled with the grant.
- core_wdata  in  DW  core write data; sampled with the grant.
- core_rdata  out  DW  read data; valid with `core_ack` of a read and held until the next core read ack.
- core_ack  out  1  one-cycle completion pulse.
- dma_req, dma_we, dma_addr, dma_wdata, dma_rdata, dma_ack  same widths and meanings as the core_* signals, for the DMA port.
- mem_en  out  1  memory access strobe; high for exactly one cycle per transaction.
- mem_we  out  1  write enable; high only together with `mem_en`.
- mem_addr  out  AW  registered address.
- mem_wdata  out  DW  registered write data.
- mem_rdata  in  DW  memory read data; valid RD_LAT cycles after the `mem_en` cycle.

## Operation
- States:
  - IDLE: arbitrate.
  - ISSUE: drive `mem_en`.
  - WAIT: read latency countdown.
  - ACK: pulse ack.
- IDLE:
  - No request: stay in IDLE.
  - A request is pending: latch owner, we, addr and wdata into `mem_*` registers, then go to ISSUE.
- Arbitration:
  - Only one request pending: that requester wins.
  - Both pending: the requester not served last wins. `last` register is 1 bit; after reset it points to DMA, so the core wins the first tie.
  - `last` updates on entry to ISSUE.
- ISSUE: `mem_en`=1 and `mem_we`=latched we. On a write go to ACK. On a read load the counter with RD_LAT-1 and go to WAIT.
- WAIT: the counter decrements each cycle. When it reaches 0, capture `mem_rdata` into the owner's rdata register and go to ACK.
- ACK: assert the owner's ack for one cycle, then go to IDLE. The other port's ack and rdata are untouched.
- Back-to-back: if the requester keeps req high after ack, it is treated as a new request in the following IDLE cycle, with new fields sampled. If the other side is also waiting, round-robin alternates the two.
- A requester dropping req after the grant does not abort the transaction. It completes and ack is still pulsed.
- Requests arriving during ISSUE, WAIT or ACK wait for IDLE.
- `mem_addr` and `mem_wdata` hold their last values between transactions.

## Timing
- Reset (asynchronous assert, synchronous-release semantics on the next edge):
  - State = IDLE, `last` = DMA.
  - `mem_en`, `mem_we`, `core_ack`, `dma_ack` = 0.
  - `mem_addr`, `mem_wdata`, `core_rdata`, `dma_rdata` = 0.
  - Reset mid-transaction abandons it; no ack is generated.
- Request first seen high in IDLE at cycle t:
  - Cycle t+1: ISSUE.
  - Write: ack at cycle t+2 (2-cycle latency).
  - Read: WAIT occupies t+2..t+1+RD_LAT; rdata is captured at the end of cycle t+1+RD_LAT; ack and valid rdata appear at t+2+RD_LAT.
- Throughput for one continuously requesting port: one write per 3 cycles; one read per RD_LAT+3 cycles.
- Worst-case wait for a requester while the other is active: one full transaction plus one IDLE cycle.

## Test plan
- RD_LAT=2. Core read of addr 0x10, memory model returns 0xDEADBEEF. Required: `mem_en` 1 cycle after req; `core_ack` 4 cycles after req; `core_rdata`=0xDEADBEEF held afterwards; `dma_ack` never asserted.
- Both req high in the first cycle after reset, both writes. Required: core served first, DMA second, each with a 2-cycle write latency; exactly one `mem_en` per transaction.
- Both requesters hold req high for 6 transactions. Required: strict alternation C,D,C,D,C,D; no two `mem_en` pulses closer than 3 cycles.
- DMA read in progress, RD_LAT=4; core req rises during WAIT. Required: core is not issued until after `dma_ack` plus one IDLE cycle; `dma_rdata` is correct.
- rst_n low during WAIT of a core read. Required: all outputs reset immediately; no `core_ack` afterwards; a fresh request after release is served normally.
- DMA drops req one cycle after grant, write of 0x55 to 0x20. Required: the write reaches memory and `dma_ack` still pulses at t+2.

Source files
------------

// File: rtl/rv_mem_arb_if.sv
// Bus bundle between the memory arbiter, its two requesters and the memory.
// The arbiter takes the slave view (it serves the requests and drives the
// memory port); the requesters and the memory model take the master view.
//
// Handshake: a requester raises req together with we/addr/wdata and holds
// them until the one-cycle ack. The fields are sampled once, in the cycle the
// request is granted. For a read, rdata is valid with the ack and stays
// unchanged until the next read ack on that port.
interface rv_mem_arb_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          core_req;
    logic          core_we;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata;
    logic [DW-1:0] core_rdata;
    logic          core_ack;

    logic          dma_req;
    logic          dma_we;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic [DW-1:0] dma_rdata;
    logic          dma_ack;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        output core_rdata, core_ack,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_rdata, dma_ack,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata,
        input  core_rdata, core_ack,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_rdata, dma_ack,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/rv_mem_arb.sv
// Two-port round-robin arbiter in front of the single-port synchronous main
// memory. One transaction is in flight at a time: IDLE arbitrates and latches
// the winner's fields, ISSUE strobes the memory, WAIT counts out the read
// latency, ACK pulses the owner's acknowledge.
// RD_LAT must lie in 1..4; the latency counter is two bits wide.
module rv_mem_arb #(
    parameter int RD_LAT = 1,
    parameter int AW     = 32,
    parameter int DW     = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    rv_mem_arb_if.slave    bus,
    output logic [1:0]     dbg_state
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_ACK   = 2'd3;

    localparam logic OWN_CORE = 1'b0;
    localparam logic OWN_DMA  = 1'b1;

    localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic [1:0] cnt;
    logic       last;
    logic       owner;
    logic       we_q;

    logic       any_req;
    logic       grant_dma;
    logic       sel_we;
    logic       issue_go;
    logic       write_done;
    logic       read_done;

    assign dbg_state = state;

    // Arbitration: a lone request wins; on a tie the side not served last wins.
    always_comb begin
        any_req   = bus.core_req | bus.dma_req;
        grant_dma = bus.dma_req & (~bus.core_req | (last == OWN_CORE));
        sel_we    = grant_dma ? bus.dma_we : bus.core_we;
    end

    // Transaction milestones shared by the FSM and the response path.
    always_comb begin
        issue_go   = (state == S_IDLE) & any_req;
        write_done = (state == S_ISSUE) & we_q;
        read_done  = (state == S_WAIT) & (cnt == 2'd0);
    end

    // Next-state logic; requests seen outside IDLE simply wait for it.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (any_req) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = we_q ? S_ACK : S_WAIT;
            S_WAIT:  if (cnt == 2'd0) state_nxt = S_ACK;
            S_ACK:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register and read-latency counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= 2'd0;
        end else begin
            state <= state_nxt;
            if (state == S_ISSUE) begin
                cnt <= CNT_INIT;
            end else if ((state == S_WAIT) && (cnt != 2'd0)) begin
                cnt <= cnt - 2'd1;
            end
        end
    end

    // Grant latch: owner, direction and the memory address/data registers.
    // Address and write data keep their values between transactions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last          <= OWN_DMA;
            owner         <= OWN_CORE;
            we_q          <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else if (issue_go) begin
            last          <= grant_dma;
            owner         <= grant_dma;
            we_q          <= sel_we;
            bus.mem_addr  <= grant_dma ? bus.dma_addr  : bus.core_addr;
            bus.mem_wdata <= grant_dma ? bus.dma_wdata : bus.core_wdata;
        end
    end

    // Memory strobe: high only during ISSUE, write enable only alongside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.mem_en <= 1'b0;
            bus.mem_we <= 1'b0;
        end else begin
            bus.mem_en <= issue_go;
            bus.mem_we <= issue_go & sel_we;
        end
    end

    // Response path: one-cycle ack to the owner, read data captured for it only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.core_ack   <= 1'b0;
            bus.dma_ack    <= 1'b0;
            bus.core_rdata <= '0;
            bus.dma_rdata  <= '0;
        end else begin
            bus.core_ack <= (write_done | read_done) & (owner == OWN_CORE);
            bus.dma_ack  <= (write_done | read_done) & (owner == OWN_DMA);
            if (read_done && (owner == OWN_CORE)) begin
                bus.core_rdata <= bus.mem_rdata;
            end
            if (read_done && (owner == OWN_DMA)) begin
                bus.dma_rdata <= bus.mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_rv_mem_arb.sv
// Directed bench for rv_mem_arb. Two instances: RD_LAT=2 for most scenarios,
// RD_LAT=4 for the DMA read with a core request arriving during WAIT.
module tb_rv_mem_arb;

    localparam int LAT2 = 2;
    localparam int LAT4 = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rv_mem_arb_if #(.AW(32), .DW(32)) bus2 ();
    rv_mem_arb_if #(.AW(32), .DW(32)) bus4 ();
    logic [1:0] st2;
    logic [1:0] st4;

    rv_mem_arb #(.RD_LAT(LAT2), .AW(32), .DW(32)) u2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2), .dbg_state(st2)
    );
    rv_mem_arb #(.RD_LAT(LAT4), .AW(32), .DW(32)) u4 (
        .clk(clk), .rst_n(rst_n), .bus(bus4), .dbg_state(st4)
    );

    // ---------------- memory models ----------------
    function automatic logic [31:0] rd_model(input logic [31:0] a);
        case (a)
            32'h10:  return 32'hDEAD_BEEF;
            32'h30:  return 32'h1234_5678;
            32'h40:  return 32'hCAFE_F00D;
            default: return 32'h5A00_0000 | a;
        endcase
    endfunction

    logic [31:0] pd2 [4];
    logic [3:0]  pv2;
    logic [31:0] pd4 [4];
    logic [3:0]  pv4;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv2 <= '0;
            pv4 <= '0;
        end else begin
            pv2 <= {pv2[2:0], bus2.mem_en & ~bus2.mem_we};
            pv4 <= {pv4[2:0], bus4.mem_en & ~bus4.mem_we};
            pd2[0] <= rd_model(bus2.mem_addr);
            pd4[0] <= rd_model(bus4.mem_addr);
            for (int k = 1; k < 4; k++) begin
                pd2[k] <= pd2[k-1];
                pd4[k] <= pd4[k-1];
            end
        end
    end

    assign bus2.mem_rdata = pv2[LAT2-1] ? pd2[LAT2-1] : 32'hBAD0_BAD0;
    assign bus4.mem_rdata = pv4[LAT4-1] ? pd4[LAT4-1] : 32'hBAD0_BAD0;

    // ---------------- monitor ----------------
    int          en2_cnt = 0;
    int          core_ack2_cnt = 0;
    int          dma_ack2_cnt = 0;
    logic [31:0] en2_addr [$];
    int          en2_t [$];

    always @(negedge clk) begin
        if (bus2.mem_en) begin
            en2_cnt <= en2_cnt + 1;
            en2_addr.push_back(bus2.mem_addr);
            en2_t.push_back(cyc);
        end
        if (bus2.core_ack) core_ack2_cnt <= core_ack2_cnt + 1;
        if (bus2.dma_ack)  dma_ack2_cnt  <= dma_ack2_cnt + 1;
    end

    // ---------------- scoreboard / checking ----------------
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic core2(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
        bus2.core_req = req; bus2.core_we = we; bus2.core_addr = a; bus2.core_wdata = d;
    endtask

    task automatic dma2(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
        bus2.dma_req = req; bus2.dma_we = we; bus2.dma_addr = a; bus2.dma_wdata = d;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int e0;
        int a0;
        int s;
        int nc;
        int nd;

        core2(1'b0, 1'b0, 32'h0, 32'h0);
        dma2(1'b0, 1'b0, 32'h0, 32'h0);
        bus4.core_req = 1'b0; bus4.core_we = 1'b0; bus4.core_addr = '0; bus4.core_wdata = '0;
        bus4.dma_req  = 1'b0; bus4.dma_we  = 1'b0; bus4.dma_addr  = '0; bus4.dma_wdata  = '0;

        // Reset values
        tick(); tick();
        check("rst_state", {30'd0, st2}, 32'd0);
        check("rst_mem_en", {31'd0, bus2.mem_en}, 32'd0);
        check("rst_mem_addr", bus2.mem_addr, 32'd0);
        check("rst_core_rdata", bus2.core_rdata, 32'd0);
        check("rst_dma_ack", {31'd0, bus2.dma_ack}, 32'd0);
        rst_n = 1'b1;
        tick();

        // T1: core read of 0x10, RD_LAT=2
        core2(1'b1, 1'b0, 32'h10, 32'h0);
        check("t1_en_t0", {31'd0, bus2.mem_en}, 32'd0);
        tick();
        check("t1_en_t1", {31'd0, bus2.mem_en}, 32'd1);
        check("t1_addr", bus2.mem_addr, 32'h10);
        check("t1_we", {31'd0, bus2.mem_we}, 32'd0);
        tick();
        check("t1_en_t2", {31'd0, bus2.mem_en}, 32'd0);
        check("t1_state_wait", {30'd0, st2}, 32'd2);
        tick();
        check("t1_ack_t3", {31'd0, bus2.core_ack}, 32'd0);
        tick();
        check("t1_ack_t4", {31'd0, bus2.core_ack}, 32'd1);
        check("t1_rdata", bus2.core_rdata, 32'hDEAD_BEEF);
        core2(1'b0, 1'b0, 32'h10, 32'h0);
        tick();
        check("t1_ack_t5", {31'd0, bus2.core_ack}, 32'd0);
        check("t1_rdata_hold", bus2.core_rdata, 32'hDEAD_BEEF);
        check("t1_no_dma_ack", dma_ack2_cnt, 32'd0);

        // T2: both write right after reset; core first
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        e0 = en2_cnt;
        core2(1'b1, 1'b1, 32'h04, 32'h1111_1111);
        dma2(1'b1, 1'b1, 32'h84, 32'h2222_2222);
        tick();
        check("t2_c_en", {31'd0, bus2.mem_en}, 32'd1);
        check("t2_c_we", {31'd0, bus2.mem_we}, 32'd1);
        check("t2_c_addr", bus2.mem_addr, 32'h04);
        check("t2_c_wdata", bus2.mem_wdata, 32'h1111_1111);
        tick();
        check("t2_c_ack", {31'd0, bus2.core_ack}, 32'd1);
        check("t2_d_ack_early", {31'd0, bus2.dma_ack}, 32'd0);
        core2(1'b0, 1'b0, 32'h04, 32'h0);
        tick();
        check("t2_idle_en", {31'd0, bus2.mem_en}, 32'd0);
        tick();
        check("t2_d_en", {31'd0, bus2.mem_en}, 32'd1);
        check("t2_d_addr", bus2.mem_addr, 32'h84);
        check("t2_d_wdata", bus2.mem_wdata, 32'h2222_2222);
        tick();
        check("t2_d_ack", {31'd0, bus2.dma_ack}, 32'd1);
        check("t2_c_ack_quiet", {31'd0, bus2.core_ack}, 32'd0);
        dma2(1'b0, 1'b0, 32'h84, 32'h0);
        tick();
        check("t2_en_count", en2_cnt - e0, 32'd2);

        // T3: both hold req for 6 transactions; strict alternation
        exp_q = '{32'h100, 32'h200, 32'h104, 32'h204, 32'h108, 32'h208};
        s = en2_addr.size();
        nc = 0;
        nd = 0;
        core2(1'b1, 1'b1, 32'h100, 32'hC0);
        dma2(1'b1, 1'b1, 32'h200, 32'hD0);
        for (int i = 0; i < 40 && (nc < 3 || nd < 3); i++) begin
            tick();
            if (bus2.core_ack) begin
                nc++;
                if (nc == 3) bus2.core_req = 1'b0;
                else bus2.core_addr = bus2.core_addr + 32'd4;
            end
            if (bus2.dma_ack) begin
                nd++;
                if (nd == 3) bus2.dma_req = 1'b0;
                else bus2.dma_addr = bus2.dma_addr + 32'd4;
            end
        end
        core2(1'b0, 1'b0, 32'h0, 32'h0);
        dma2(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        check("t3_core_acks", nc, 32'd3);
        check("t3_dma_acks", nd, 32'd3);
        check("t3_issue_count", en2_addr.size() - s, 32'd6);
        if (en2_addr.size() >= s + 6) begin
            for (int k = 0; k < 6; k++) begin
                check($sformatf("t3_order%0d", k), en2_addr[s+k], exp_q[k]);
                if (k > 0)
                    check($sformatf("t3_gap%0d", k), en2_t[s+k] - en2_t[s+k-1], 32'd3);
            end
        end

        // T4: DMA read with RD_LAT=4, core arrives during WAIT
        bus4.dma_req = 1'b1; bus4.dma_we = 1'b0; bus4.dma_addr = 32'h30;
        tick();
        check("t4_d_en", {31'd0, bus4.mem_en}, 32'd1);
        check("t4_d_addr", bus4.mem_addr, 32'h30);
        tick();
        tick();
        check("t4_state_wait", {30'd0, st4}, 32'd2);
        bus4.core_req = 1'b1; bus4.core_we = 1'b0; bus4.core_addr = 32'h10;
        tick(); tick();
        check("t4_d_ack_early", {31'd0, bus4.dma_ack}, 32'd0);
        tick();
        check("t4_d_ack", {31'd0, bus4.dma_ack}, 32'd1);
        check("t4_d_rdata", bus4.dma_rdata, 32'h1234_5678);
        check("t4_en_in_ack", {31'd0, bus4.mem_en}, 32'd0);
        bus4.dma_req = 1'b0;
        tick();
        check("t4_en_idle", {31'd0, bus4.mem_en}, 32'd0);
        tick();
        check("t4_c_en", {31'd0, bus4.mem_en}, 32'd1);
        check("t4_c_addr", bus4.mem_addr, 32'h10);
        tick(); tick(); tick(); tick();
        check("t4_c_ack_early", {31'd0, bus4.core_ack}, 32'd0);
        tick();
        check("t4_c_ack", {31'd0, bus4.core_ack}, 32'd1);
        check("t4_c_rdata", bus4.core_rdata, 32'hDEAD_BEEF);
        check("t4_d_rdata_hold", bus4.dma_rdata, 32'h1234_5678);
        bus4.core_req = 1'b0;
        tick();

        // T5: reset during WAIT of a core read
        core2(1'b1, 1'b0, 32'h10, 32'h0);
        tick(); tick(); tick(); tick();
        check("t5_pre_ack", {31'd0, bus2.core_ack}, 32'd1);
        check("t5_pre_rdata", bus2.core_rdata, 32'hDEAD_BEEF);
        core2(1'b0, 1'b0, 32'h10, 32'h0);
        tick();
        core2(1'b1, 1'b0, 32'h40, 32'h0);
        tick();
        check("t5_issue_addr", bus2.mem_addr, 32'h40);
        tick();
        check("t5_in_wait", {30'd0, st2}, 32'd2);
        a0 = core_ack2_cnt;
        rst_n = 1'b0;
        #1;
        check("t5_rst_state", {30'd0, st2}, 32'd0);
        check("t5_rst_addr", bus2.mem_addr, 32'd0);
        check("t5_rst_rdata", bus2.core_rdata, 32'd0);
        check("t5_rst_en", {31'd0, bus2.mem_en}, 32'd0);
        core2(1'b0, 1'b0, 32'h0, 32'h0);
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check("t5_no_ack", core_ack2_cnt - a0, 32'd0);
        core2(1'b1, 1'b0, 32'h40, 32'h0);
        tick();
        check("t5_new_en", {31'd0, bus2.mem_en}, 32'd1);
        tick(); tick(); tick();
        check("t5_new_ack", {31'd0, bus2.core_ack}, 32'd1);
        check("t5_new_rdata", bus2.core_rdata, 32'hCAFE_F00D);
        core2(1'b0, 1'b0, 32'h0, 32'h0);
        tick();

        // T6: DMA write drops req one cycle after grant
        e0 = en2_cnt;
        dma2(1'b1, 1'b1, 32'h20, 32'h55);
        tick();
        check("t6_en", {31'd0, bus2.mem_en}, 32'd1);
        check("t6_we", {31'd0, bus2.mem_we}, 32'd1);
        check("t6_addr", bus2.mem_addr, 32'h20);
        check("t6_wdata", bus2.mem_wdata, 32'h55);
        dma2(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        check("t6_ack", {31'd0, bus2.dma_ack}, 32'd1);
        tick();
        check("t6_ack_once", {31'd0, bus2.dma_ack}, 32'd0);
        tick(); tick(); tick();
        check("t6_en_count", en2_cnt - e0, 32'd1);
        check("t6_addr_hold", bus2.mem_addr, 32'h20);
        check("t6_wdata_hold", bus2.mem_wdata, 32'h55);

        // Final report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
